// File: rtl/sdio_blkseq.sv
// Ping-pong FIFO block sequencer: one engine request per block, FIFOs alternate A/B.
// Latency: SEL->o_dat_stb 1 cycle; done->next o_dat_stb 2 cycles; stalls in SEL until the next FIFO is usable.
module sdio_blkseq #(
  parameter int LGNBLK    = 16,
  parameter int LGTIMEOUT = 26
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic              i_dir,
  input  logic [LGNBLK-1:0] i_nblk,
  input  logic              i_abort,
  input  logic [1:0]        i_host_rel,
  output logic              o_dat_stb,
  output logic              o_dat_fifo,
  input  logic              i_dat_done,
  input  logic              i_dat_err,
  output logic              o_dat_abort,
  output logic [1:0]        o_fifo_valid,
  output logic [1:0]        o_host_int,
  output logic              o_busy,
  output logic [1:0]        o_errcode,
  output logic [LGNBLK-1:0] o_blk_rem
);

  typedef enum logic [1:0] {IDLE, SEL, XFER} state_t;

  state_t                 state_q, state_d;
  logic                   dir_q, dir_d;
  logic                   next_q, next_d;
  logic [1:0]             valid_q, valid_d;
  logic [LGTIMEOUT-1:0]   wd_q, wd_d;
  logic                   stb_q, stb_d;
  logic                   dabort_q, dabort_d;
  logic [1:0]             hint_q, hint_d;
  logic                   busy_q, busy_d;
  logic [1:0]             err_q, err_d;
  logic [LGNBLK-1:0]      rem_q, rem_d;

  logic [1:0] usable, owned, rel;

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    next_d   = next_q;
    wd_d     = wd_q;
    stb_d    = 1'b0;
    dabort_d = 1'b0;
    hint_d   = 2'b00;
    busy_d   = busy_q;
    err_d    = err_q;
    rem_d    = rem_q;

    usable = dir_q ? valid_q : ~valid_q;
    // The FIFO the engine is working on cannot be handed back by the host.
    owned  = (state_q == XFER) ? (2'b01 << next_q) : 2'b00;
    rel    = i_host_rel & ~owned;
    valid_d = dir_q ? (valid_q | rel) : (valid_q & ~rel);

    case (state_q)
      IDLE: begin
        dir_d = i_dir;
        if (i_start) begin
          rem_d   = (i_nblk == '0) ? LGNBLK'(1) : i_nblk;
          next_d  = 1'b0;
          err_d   = 2'b00;
          busy_d  = 1'b1;
          state_d = SEL;
        end
      end
      SEL: begin
        if (i_abort) begin
          err_d   = 2'b11;
          valid_d = 2'b00;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (usable[next_q]) begin
          stb_d   = 1'b1;
          wd_d    = '1;
          state_d = XFER;
        end
      end
      XFER: begin
        if (i_abort) begin
          dabort_d = 1'b1;
          err_d    = 2'b11;
          valid_d  = 2'b00;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else if (i_dat_done) begin
          if (i_dat_err) begin
            err_d   = 2'b01;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            valid_d[next_q] = ~dir_q;
            hint_d[next_q]  = 1'b1;
            rem_d           = rem_q - LGNBLK'(1);
            next_d          = ~next_q;
            if (rem_q == LGNBLK'(1)) begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              state_d = SEL;
            end
          end
        end else if (wd_q == '0) begin
          dabort_d = 1'b1;
          err_d    = 2'b10;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          wd_d = wd_q - LGTIMEOUT'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      dir_q    <= 1'b0;
      next_q   <= 1'b0;
      valid_q  <= 2'b00;
      wd_q     <= '0;
      stb_q    <= 1'b0;
      dabort_q <= 1'b0;
      hint_q   <= 2'b00;
      busy_q   <= 1'b0;
      err_q    <= 2'b00;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      next_q   <= next_d;
      valid_q  <= valid_d;
      wd_q     <= wd_d;
      stb_q    <= stb_d;
      dabort_q <= dabort_d;
      hint_q   <= hint_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      rem_q    <= rem_d;
    end
  end

  assign o_dat_stb    = stb_q;
  assign o_dat_fifo   = next_q;
  assign o_dat_abort  = dabort_q;
  assign o_fifo_valid = valid_q;
  assign o_host_int   = hint_q;
  assign o_busy       = busy_q;
  assign o_errcode    = err_q;
  assign o_blk_rem    = rem_q;

endmodule

// File: tb/tb_sdio_blkseq.sv
// Directed bench for sdio_blkseq: stimulus queues expected engine/host events, a negedge monitor pops and compares them.
module tb_sdio_blkseq;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_dir = 1'b0;
  logic [15:0] i_nblk = 16'd0;
  logic        i_abort = 1'b0;
  logic [1:0]  i_host_rel = 2'b00;
  logic        i_dat_done = 1'b0;
  logic        i_dat_err = 1'b0;
  logic        o_dat_stb, o_dat_fifo, o_dat_abort, o_busy;
  logic [1:0]  o_fifo_valid, o_host_int, o_errcode;
  logic [15:0] o_blk_rem;

  sdio_blkseq #(.LGNBLK(16), .LGTIMEOUT(4)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_dir(i_dir),
    .i_nblk(i_nblk), .i_abort(i_abort), .i_host_rel(i_host_rel),
    .o_dat_stb(o_dat_stb), .o_dat_fifo(o_dat_fifo), .i_dat_done(i_dat_done),
    .i_dat_err(i_dat_err), .o_dat_abort(o_dat_abort), .o_fifo_valid(o_fifo_valid),
    .o_host_int(o_host_int), .o_busy(o_busy), .o_errcode(o_errcode), .o_blk_rem(o_blk_rem)
  );

  always #5 i_clk = ~i_clk;

  localparam logic [1:0] K_STB = 2'd1, K_INT = 2'd2, K_ABT = 2'd3;
  typedef struct packed {
    logic [1:0]  kind;
    logic [1:0]  id;
    logic [15:0] rem;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk = 0;
  int  n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [1:0] id, input logic [15:0] rem);
    ev_t e;
    e.kind = kind; e.id = id; e.rem = rem;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [1:0] kind, input logic [1:0] id, input logic [15:0] rem);
    ev_t e, a;
    a.kind = kind; a.id = id; a.rem = rem;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", {12'd0, a}, 32'h0);
    end else begin
      e = exp_q.pop_front();
      chk("event", {12'd0, a}, {12'd0, e});
    end
  endtask

  // Monitor: every output event must match the head of the expectation queue.
  always @(negedge i_clk) begin
    if (i_reset_n) begin
      if (o_dat_stb)          pop_cmp(K_STB, {1'b0, o_dat_fifo}, o_blk_rem);
      if (o_host_int != 2'b0) pop_cmp(K_INT, o_host_int, o_blk_rem);
      if (o_dat_abort)        pop_cmp(K_ABT, 2'b00, o_blk_rem);
    end
  end

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_stb(input int lim);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i <= lim; i++) begin
      if (o_dat_stb) begin
        seen = 1'b1;
        break;
      end
      cyc();
    end
    chk("stb_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic start(input logic [15:0] n);
    i_nblk = n; i_start = 1'b1;
    cyc();
    i_start = 1'b0;
  endtask

  task automatic done(input logic err);
    i_dat_done = 1'b1; i_dat_err = err;
    cyc();
    i_dat_done = 1'b0; i_dat_err = 1'b0;
  endtask

  task automatic rel(input logic [1:0] r);
    i_host_rel = r;
    cyc();
    i_host_rel = 2'b00;
  endtask

  function automatic logic [31:0] all_outs();
    return {6'd0, o_dat_stb, o_dat_fifo, o_dat_abort, o_fifo_valid, o_host_int,
            o_busy, o_errcode, o_blk_rem};
  endfunction

  initial begin
    int k;
    #2;
    chk("reset_outputs", all_outs(), 32'h0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    cyc();

    // 1: write, 3 blocks, both FIFOs pre-filled, A refilled after first int
    i_dir = 1'b1;
    cyc();
    rel(2'b11);
    chk("t1_prefill", {30'd0, o_fifo_valid}, 32'h3);
    push(K_STB, 2'd0, 16'd3);
    start(16'd3);
    chk("t1_busy", {31'd0, o_busy}, 32'd1);
    wait_stb(4);
    push(K_INT, 2'b01, 16'd2);
    push(K_STB, 2'd1, 16'd2);
    done(1'b0);
    rel(2'b01);
    wait_stb(4);
    push(K_INT, 2'b10, 16'd1);
    push(K_STB, 2'd0, 16'd1);
    done(1'b0);
    wait_stb(4);
    push(K_INT, 2'b01, 16'd0);
    done(1'b0);
    chk("t1_end", {25'd0, o_busy, o_errcode, o_fifo_valid, o_blk_rem[1:0]}, 32'h0);

    // 2: read, host never drains; stalls in SEL until A released
    i_dir = 1'b0;
    cyc();
    push(K_STB, 2'd0, 16'd3);
    start(16'd3);
    wait_stb(4);
    push(K_INT, 2'b01, 16'd2);
    push(K_STB, 2'd1, 16'd2);
    done(1'b0);
    wait_stb(4);
    push(K_INT, 2'b10, 16'd1);
    done(1'b0);
    repeat (6) cyc();
    chk("t2_hold_busy", {31'd0, o_busy}, 32'd1);
    chk("t2_hold_valid", {30'd0, o_fifo_valid}, 32'h3);
    chk("t2_hold_rem", {16'd0, o_blk_rem}, 32'd1);
    push(K_STB, 2'd0, 16'd1);
    rel(2'b01);
    wait_stb(1);
    push(K_INT, 2'b01, 16'd0);
    done(1'b0);
    chk("t2_end_busy", {31'd0, o_busy}, 32'd0);

    // 3: write, 4 blocks, CRC error on the second
    i_dir = 1'b1;
    cyc();
    push(K_STB, 2'd0, 16'd4);
    start(16'd4);
    wait_stb(4);
    push(K_INT, 2'b01, 16'd3);
    push(K_STB, 2'd1, 16'd3);
    done(1'b0);
    wait_stb(4);
    done(1'b1);
    chk("t3_err", {30'd0, o_errcode}, 32'd1);
    chk("t3_busy", {31'd0, o_busy}, 32'd0);
    chk("t3_rem", {16'd0, o_blk_rem}, 32'd3);
    chk("t3_valid", {30'd0, o_fifo_valid}, 32'h2);

    // 4: watchdog, nblk=0 treated as 1
    rel(2'b01);
    push(K_STB, 2'd0, 16'd1);
    start(16'd0);
    chk("t4_rem", {16'd0, o_blk_rem}, 32'd1);
    wait_stb(4);
    push(K_ABT, 2'd0, 16'd1);
    k = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      k++;
      if (o_dat_abort) break;
    end
    chk("t4_latency", k, 32'd16);
    chk("t4_err", {30'd0, o_errcode}, 32'd2);
    chk("t4_busy", {31'd0, o_busy}, 32'd0);
    repeat (4) cyc();

    // 5: abort colliding with done
    push(K_STB, 2'd0, 16'd2);
    start(16'd2);
    wait_stb(4);
    push(K_ABT, 2'd0, 16'd2);
    i_abort = 1'b1;
    done(1'b0);
    i_abort = 1'b0;
    chk("t5_err", {30'd0, o_errcode}, 32'd3);
    chk("t5_valid", {30'd0, o_fifo_valid}, 32'h0);
    chk("t5_rem", {16'd0, o_blk_rem}, 32'd2);
    chk("t5_busy", {31'd0, o_busy}, 32'd0);
    repeat (3) cyc();

    // 6: restart while busy is ignored; async reset mid-transfer
    rel(2'b11);
    push(K_STB, 2'd0, 16'd5);
    start(16'd5);
    start(16'd9);
    wait_stb(4);
    chk("t6_rem", {16'd0, o_blk_rem}, 32'd5);
    @(negedge i_clk);
    #1;
    i_reset_n = 1'b0;
    #1;
    chk("t6_reset_outputs", all_outs(), 32'h0);
    cyc();
    cyc();
    i_reset_n = 1'b1;
    repeat (4) cyc();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
